// File: rtl/shift_add_multiplier_if.sv
// Handshake/data bundle between the control logic and the shift-add multiplier.
interface shift_add_multiplier_if #(
    parameter int nBit = 8
);
    logic              start;
    logic [nBit-1:0]   A;
    logic [nBit-1:0]   B;
    logic              busy;
    logic              done;
    logic [2*nBit-1:0] product;

    // Control side: issues requests, observes status and result.
    modport master (
        output start, A, B,
        input  busy, done, product
    );

    // Multiplier side: accepts requests, reports status and result.
    modport slave (
        input  start, A, B,
        output busy, done, product
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one multiplier bit per clock, fixed nBit-cycle
// latency, start/busy/done handshake, registered product held between operations.
module shift_add_multiplier #(
    parameter int nBit = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    shift_add_multiplier_if.slave bus
);
    localparam int PW = 2 * nBit;
    localparam int CW = $clog2(nBit) + 1;
    localparam logic [CW-1:0] LAST = CW'(nBit - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [PW-1:0]     mcand;
    logic [nBit-1:0]   mplier;
    logic [PW-1:0]     acc;
    logic [CW-1:0]     count;
    logic              busy_q;
    logic              done_q;
    logic [PW-1:0]     product_q;
    logic [PW-1:0]     acc_next;

    // Accumulator value after this cycle's conditional add; the add cannot
    // overflow because acc never exceeds (2^nBit-1)^2.
    always_comb begin
        acc_next = acc;
        if (mplier[0])
            acc_next = acc + mcand;
    end

    // Control FSM plus datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            count     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand  <= PW'(bus.A);
                        mplier <= bus.B;
                        acc    <= '0;
                        count  <= '0;
                        busy_q <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    // Last iteration: publish the sum including this edge's add.
                    if (count == LAST) begin
                        product_q <= acc_next;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // start is not queued here; the caller retries in IDLE.
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: nBit=8 scenarios plus an exhaustive nBit=4 sweep.
module tb_shift_add_multiplier;
    logic clk = 1'b0;
    logic rst8, rst4;
    int checks = 0;
    int failures = 0;
    logic [15:0] exp8 = '0;   // product the 8-bit DUT should be holding
    logic [7:0]  exp4 = '0;

    always #5 clk = ~clk;

    shift_add_multiplier_if #(.nBit(8)) if8 ();
    shift_add_multiplier_if #(.nBit(4)) if4 ();

    shift_add_multiplier #(.nBit(8)) dut8 (.clk(clk), .rst(rst8), .bus(if8.slave));
    shift_add_multiplier #(.nBit(4)) dut4 (.clk(clk), .rst(rst4), .bus(if4.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 8-bit multiply from IDLE. mid: pulse start(100,100) during CALC.
    // done_start: raise start(3,5) on the done cycle and leave it high.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                        input bit mid, input bit done_start);
        if8.A = a; if8.B = b; if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("busy8", 32'(if8.busy), 1);
            chk("done8_calc", 32'(if8.done), 0);
            chk("prod8_hold", 32'(if8.product), 32'(exp8));
            if8.A = 8'(i * 37); if8.B = 8'(i * 91);
            if (mid && i == 2) begin if8.start = 1'b1; if8.A = 100; if8.B = 100; end
            if (mid && i == 3) if8.start = 1'b0;
            tick();
        end
        exp8 = exp;
        chk("done8", 32'(if8.done), 1);
        chk("busy8_done", 32'(if8.busy), 0);
        chk("prod8", 32'(if8.product), 32'(exp));
        if (done_start) begin if8.start = 1'b1; if8.A = 3; if8.B = 5; end
        tick();
        chk("done8_off", 32'(if8.done), 0);
        chk("busy8_idle", 32'(if8.busy), 0);
        chk("prod8_after", 32'(if8.product), 32'(exp));
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
        if4.A = a; if4.B = b; if4.start = 1'b1;
        tick();
        if4.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("busy4", 32'(if4.busy), 1);
            chk("prod4_hold", 32'(if4.product), 32'(exp4));
            tick();
        end
        exp4 = exp;
        chk("done4", 32'(if4.done), 1);
        chk("prod4", 32'(if4.product), 32'(exp));
        tick();
        chk("done4_off", 32'(if4.done), 0);
    endtask

    initial begin
        int seen_done;
        rst8 = 1'b1; rst4 = 1'b1;
        if8.start = 1'b0; if8.A = '0; if8.B = '0;
        if4.start = 1'b0; if4.A = '0; if4.B = '0;
        tick();
        tick();
        rst8 = 1'b0; rst4 = 1'b0;
        chk("rst_busy8", 32'(if8.busy), 0);
        chk("rst_done8", 32'(if8.done), 0);
        chk("rst_prod8", 32'(if8.product), 0);
        chk("rst_prod4", 32'(if4.product), 0);

        // Basic and extremes
        run8(8'd13, 8'd11, 16'd143, 1'b0, 1'b0);
        tick();
        chk("basic_hold", 32'(if8.product), 143);
        run8(8'd255, 8'd255, 16'hFE01, 1'b0, 1'b0);
        run8(8'd0, 8'd200, 16'd0, 1'b0, 1'b0);
        run8(8'd1, 8'd255, 16'd255, 1'b0, 1'b0);

        // Ignored start in CALC and on the done cycle, then accepted retry
        run8(8'd6, 8'd7, 16'd42, 1'b1, 1'b1);
        run8(8'd3, 8'd5, 16'd15, 1'b0, 1'b0);

        // Reset in the 4th busy cycle
        if8.A = 200; if8.B = 150; if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        tick(); tick(); tick();
        chk("busy8_pre_rst", 32'(if8.busy), 1);
        rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        chk("midrst_busy", 32'(if8.busy), 0);
        chk("midrst_done", 32'(if8.done), 0);
        chk("midrst_prod", 32'(if8.product), 0);
        exp8 = '0;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (if8.done || if8.busy) seen_done++;
        end
        chk("midrst_quiet", 32'(seen_done), 0);
        run8(8'd2, 8'd3, 16'd6, 1'b0, 1'b0);

        // Hold between operations, then back-to-back update
        run8(8'd9, 8'd9, 16'd81, 1'b0, 1'b0);
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            if8.A = 8'(i * 13 + 1); if8.B = 8'(i * 29 + 7);
            tick();
            if (if8.product !== 16'd81 || if8.busy || if8.done) seen_done++;
        end
        chk("hold_81", 32'(seen_done), 0);
        run8(8'd12, 8'd12, 16'd144, 1'b0, 1'b0);

        // nBit=4 exhaustive sweep against a*b
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run4(4'(a), 4'(b), 8'(a * b));
        chk("sweep_15x15", 32'(if4.product), 225);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
